// File: rtl/murphi_rule_scheduler.sv
// rtl/murphi_rule_scheduler.sv - round-robin rule enable driver for the Murphi system block
module murphi_rule_scheduler #(
  parameter int NUM_RULES      = 4,
  parameter int IDX_W          = $clog2(NUM_RULES),
  parameter int CNT_W          = 16,
  parameter int DEADLOCK_LIMIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_run,
  input  logic                 io_step,
  input  logic [NUM_RULES-1:0] io_guard,
  input  logic [NUM_RULES-1:0] io_mask,
  output logic [NUM_RULES-1:0] io_en_a,
  output logic [IDX_W-1:0]     io_fire_idx,
  output logic [CNT_W-1:0]     io_fire_count,
  output logic                 io_deadlock,
  output logic                 io_busy
);

  localparam int IC_W = $clog2(DEADLOCK_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_FIRE,
    S_SETTLE,
    S_DEADLOCK
  } state_t;

  state_t               state, state_nxt;
  logic                 mode_run;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_q;
  logic [IC_W-1:0]      idle_cnt;
  logic [NUM_RULES-1:0] eligible;
  logic [NUM_RULES-1:0] rot;
  logic [IDX_W-1:0]     pick_off;
  logic [IDX_W:0]       pick_sum;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;

  assign eligible = io_guard & ~io_mask;
  assign io_busy  = (state != S_IDLE);

  // Rotate so bit 0 is rr_ptr, take the lowest set bit, then rotate the offset back.
  always_comb begin
    rot        = NUM_RULES'({eligible, eligible} >> rr_ptr);
    pick_found = 1'b0;
    pick_off   = '0;
    for (int k = 0; k < NUM_RULES; k++) begin
      if (rot[k] && !pick_found) begin
        pick_found = 1'b1;
        pick_off   = IDX_W'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= (IDX_W+1)'(NUM_RULES)) begin
      pick_sum = pick_sum - (IDX_W+1)'(NUM_RULES);
    end
    pick_idx = pick_sum[IDX_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (io_run || io_step) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (mode_run && !io_run)                       state_nxt = S_IDLE;
        else if (pick_found)                           state_nxt = S_FIRE;
        else if (!mode_run)                            state_nxt = S_IDLE;
        else if (idle_cnt == IC_W'(DEADLOCK_LIMIT))    state_nxt = S_DEADLOCK;
      end
      S_FIRE:     state_nxt = S_SETTLE;
      S_SETTLE:   state_nxt = (mode_run && io_run) ? S_ARB : S_IDLE;
      S_DEADLOCK: begin
        if (!io_run) state_nxt = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      mode_run      <= 1'b0;
      rr_ptr        <= '0;
      grant_q       <= '0;
      idle_cnt      <= '0;
      io_en_a       <= '0;
      io_fire_idx   <= '0;
      io_fire_count <= '0;
      io_deadlock   <= 1'b0;
    end else begin
      state   <= state_nxt;
      io_en_a <= '0;
      case (state)
        S_IDLE: begin
          if (io_run || io_step) begin
            mode_run    <= io_run;
            idle_cnt    <= '0;
            io_deadlock <= 1'b0;
          end
        end
        S_ARB: begin
          if (state_nxt == S_FIRE) begin
            io_en_a  <= {{(NUM_RULES-1){1'b0}}, 1'b1} << pick_idx;
            grant_q  <= pick_idx;
            idle_cnt <= '0;
          end else if (state_nxt == S_DEADLOCK) begin
            io_deadlock <= 1'b1;
          end else if (mode_run && io_run) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_FIRE: begin
          io_fire_count <= io_fire_count + 1'b1;
          io_fire_idx   <= grant_q;
          rr_ptr        <= (grant_q == IDX_W'(NUM_RULES-1)) ? '0 : grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
